// File: rtl/deserializer_if.sv
// rtl/deserializer_if.sv - beat-in / word-out handshake bundle for the deserializer
//
// Purpose : groups the upstream beat channel (_AM) and the downstream word
//           channel (_BM) of the deserializer into one interface.
// Signals : iValid_AM / oReady_AM / iData_AM   upstream beat handshake + data
//           oValid_BM / iReady_BM / oData_BM   downstream word handshake + data
// Modports: slave  - the deserializer side (consumes beats, produces words)
//           master - the environment side (produces beats, consumes words)
interface deserializer_if #(
  parameter int WIDTH = 4,
  parameter int COUNT = 4
);
  logic                   iValid_AM;
  logic                   oReady_AM;
  logic [WIDTH-1:0]       iData_AM;
  logic                   oValid_BM;
  logic                   iReady_BM;
  logic [WIDTH*COUNT-1:0] oData_BM;

  modport slave (
    input  iValid_AM,
    input  iData_AM,
    input  iReady_BM,
    output oReady_AM,
    output oValid_BM,
    output oData_BM
  );

  modport master (
    output iValid_AM,
    output iData_AM,
    output iReady_BM,
    input  oReady_AM,
    input  oValid_BM,
    input  oData_BM
  );
endinterface

// File: rtl/deserializer.sv
// rtl/deserializer.sv - packs COUNT beats of WIDTH bits into one output word
//
// Purpose : collects COUNT upstream beats (first beat lands in the least
//           significant slot) and presents them as one WIDTH*COUNT word.
//           With BURST="yes" a new beat can be taken in the same cycle the
//           held word is handed downstream, so back-to-back words flow at
//           full beat rate.
// Ports   : iCLK    clock, all state changes on the rising edge
//           iRST    asynchronous active-low reset
//           bus_io  deserializer_if.slave (beat in, word out)
module deserializer #(
  parameter int    WIDTH = 4,
  parameter int    COUNT = 4,
  parameter string BURST = "yes"
) (
  input  logic           iCLK,
  input  logic           iRST,
  deserializer_if.slave  bus_io
);

  localparam int             CW       = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CW-1:0]  LAST     = CW'(COUNT - 1);
  localparam bit             BURST_EN = (BURST == "yes");

  // FILL collects beats, HOLD presents a completed word.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH*COUNT-1:0] data_q, data_d;

  logic ready_w;
  logic beat_xfer_w;
  logic word_xfer_w;

  // The only combinational input-to-output path is iReady_BM -> oReady_AM
  // in burst mode. Reset gates ready so nothing is accepted while held.
  always_comb begin
    ready_w = 1'b0;
    if (state_q == FILL) begin
      ready_w = 1'b1;
    end else if (BURST_EN) begin
      ready_w = bus_io.iReady_BM;
    end
    ready_w = ready_w & iRST;
  end

  assign beat_xfer_w = bus_io.iValid_AM & ready_w;
  assign word_xfer_w = (state_q == HOLD) & bus_io.iReady_BM;

  assign bus_io.oReady_AM = ready_w;
  assign bus_io.oValid_BM = (state_q == HOLD);
  assign bus_io.oData_BM  = data_q;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= FILL;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;

    case (state_q)
      FILL: begin
        if (beat_xfer_w) begin
          for (int k = 0; k < COUNT; k++) begin
            if (int'(cnt_q) == k) begin
              data_d[k*WIDTH +: WIDTH] = bus_io.iData_AM;
            end
          end
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      HOLD: begin
        if (word_xfer_w) begin
          if (beat_xfer_w) begin
            // Handoff and new beat 0 in the same cycle: the beat starts the
            // next word. A single-beat word is complete at once, so stay in
            // HOLD and keep full throughput.
            data_d[WIDTH-1:0] = bus_io.iData_AM;
            if (COUNT == 1) begin
              cnt_d   = '0;
              state_d = HOLD;
            end else begin
              cnt_d   = CW'(1);
              state_d = FILL;
            end
          end else begin
            cnt_d   = '0;
            state_d = FILL;
          end
        end
      end

      default: begin
        state_d = FILL;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the beat width in bits.
REQ-002 The block SHALL have parameter COUNT, default 4, giving the number of beats per output word (legal range 1..256).
REQ-003 The block SHALL have parameter BURST, default "yes", which enables same-cycle acceptance of a new beat while a full word is handed off ("yes"/"no").
REQ-004 iCLK  input  1  clock; all state SHALL change on its rising edge only.
REQ-005 iRST  input  1  reset, asynchronous, active-low.
REQ-006 iValid_AM  input  1  upstream beat valid.
REQ-007 oReady_AM  output  1  block can accept a beat.
REQ-008 iData_AM  input  WIDTH  upstream beat data.
REQ-009 oValid_BM  output  1  assembled word valid.
REQ-010 iReady_BM  input  1  downstream can accept the word.
REQ-011 oData_BM  output  WIDTH*COUNT  assembled word.

Function
REQ-012 A beat SHALL transfer on a rising edge where iValid_AM and oReady_AM are both high; a word SHALL transfer where oValid_BM and iReady_BM are both high.
REQ-013 The block SHALL hold a beat counter (0..COUNT-1) and a FULL flag; states: FILL (FULL=0) and HOLD (FULL=1).
REQ-014 In FILL, oReady_AM SHALL be 1; each accepted beat k SHALL be written to oData_BM[(k+1)*WIDTH-1 : k*WIDTH], and the counter SHALL increment.
REQ-015 Acceptance of beat COUNT-1 SHALL wrap the counter to 0 and enter HOLD; oValid_BM SHALL go high on that same edge (1-cycle latency from the final beat).
REQ-016 In HOLD, oData_BM and oValid_BM SHALL stay constant until a word transfer occurs.
REQ-017 In HOLD with BURST="no", oReady_AM SHALL be 0; a word transfer SHALL return the block to FILL with oValid_BM low on the next cycle.
REQ-018 In HOLD with BURST="yes", oReady_AM SHALL equal iReady_BM (combinational); a simultaneous word and beat transfer SHALL deliver the word, write the beat into slot 0, set the counter to 1, and enter FILL.
REQ-019 With COUNT=1 and BURST="yes", simultaneous word and beat transfer SHALL keep the block in HOLD with the new beat as oData_BM, giving full throughput.
REQ-020 Gaps in iValid_AM during FILL SHALL NOT alter the counter or the stored slots.
REQ-021 Slots not yet written for the current word SHALL retain prior contents; only oData_BM while oValid_BM=1 is defined.
REQ-022 No combinational path SHALL exist from iValid_AM or iData_AM to any output; the only combinational path SHALL be iReady_BM to oReady_AM (BURST="yes").

Reset
REQ-023 While iRST=0, oValid_BM SHALL be 0, oData_BM all zero, counter 0, state FILL, and oReady_AM SHALL be 0.
REQ-024 Reset asserted mid-word or in HOLD SHALL discard the partial or pending word immediately, without waiting for a clock edge.
REQ-025 After iRST deasserts, oReady_AM SHALL be 1 from the first cycle and the next accepted beat SHALL be treated as beat 0.

Verification (WIDTH=4, COUNT=4 unless stated)
REQ-026 Beats 1,2,3,4 on consecutive cycles with iReady_BM=1 -> oValid_BM high one cycle after beat 4 with oData_BM=16'h4321.
REQ-027 Word 16'h4321 held with iReady_BM=0 for 3 cycles, BURST="no" -> oReady_AM=0, data stable; iReady_BM=1 -> transfer, then oReady_AM=1.
REQ-028 BURST="yes": words 16'h4321 then 16'hDCBA streamed with iValid_AM=1 and iReady_BM=1 every cycle -> both delivered, no lost or duplicated beat, 4-cycle word spacing.
REQ-029 Beats a,_,b,_,_,c,d with gaps in iValid_AM -> single word 16'hDCBA.
REQ-030 Reset pulsed after beats 7,8 -> oValid_BM=0 at once; then beats 1,2,3,4 -> 16'h4321.
REQ-031 COUNT=1, BURST="yes": beats a,b,c,d with iReady_BM=1 -> outputs a,b,c,d one per cycle at 1-cycle latency.
